sram_like_responder: RTL and testbench

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

---
 rtl/sram_like_responder.sv | 177 +++++++++++++++++
 tb/tb_sram_like_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_responder.sv
// SRAM-like slave: request/addr_ok handshake, in-order data_ok responses at least LAT cycles
// after acceptance, byte-masked writes into a word array of 2^ADDR_W 32-bit entries.
module sram_like_responder #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 2,
    parameter int LAT    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        busy_inject,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam int               WORDS     = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] DEPTH_V   = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       LAT_V     = 3'(LAT);
    localparam logic [3:0]       LAT_W4    = 4'(LAT);
    localparam logic             BYPASS_EN = (LAT == 1);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                merged[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = '0;
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [31:0]       mem_r    [WORDS];
    logic [31:0]       q_data_r [DEPTH];
    logic [2:0]        q_age_r  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [CNT_W-1:0]  q_count_r;
    logic [CNT_W-1:0]  count_r;
    logic              data_ok_r;
    logic [31:0]       rdata_r;

    logic [ADDR_W-1:0] word_idx_s;
    logic              accept_s;
    logic              head_valid_s;
    logic              head_ready_s;
    logic              pop_s;
    logic              bypass_s;
    logic              push_s;
    logic              resp_valid_s;
    logic [31:0]       mem_word_s;
    logic [31:0]       push_data_s;
    logic [31:0]       resp_data_s;
    logic              unused_addr_s;

    assign word_idx_s    = addr[ADDR_W+1:2];
    assign unused_addr_s = ^{addr[31:ADDR_W+2], addr[1:0]};
    assign mem_word_s    = mem_r[word_idx_s];

    // count includes the transaction sitting in the output register, so a retiring
    // head still blocks acceptance in its data_ok cycle.
    assign addr_ok  = !reset && !busy_inject && (count_r < DEPTH_V);
    assign accept_s = req && addr_ok;

    assign data_ok = data_ok_r && !reset;
    assign rdata   = reset ? 32'h0 : rdata_r;

    // Pick the next response: queue head once old enough, or the new request directly when LAT is 1.
    always_comb begin
        head_valid_s = (q_count_r != '0);
        head_ready_s = ({1'b0, q_age_r[rd_ptr_r]} + 4'd1) >= LAT_W4;
        pop_s        = head_valid_s && head_ready_s;
        bypass_s     = BYPASS_EN && accept_s && !head_valid_s;
        push_s       = accept_s && !bypass_s;
        resp_valid_s = pop_s || bypass_s;
        if (wr) begin
            push_data_s = 32'h0;
        end else begin
            push_data_s = mem_word_s;
        end
        if (pop_s) begin
            resp_data_s = q_data_r[rd_ptr_r];
        end else if (bypass_s) begin
            resp_data_s = push_data_s;
        end else begin
            resp_data_s = 32'h0;
        end
    end

    // Byte-masked memory write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && wr) begin
            mem_r[word_idx_s] <= merge_bytes(mem_word_s, wdata, wstrb);
        end
    end

    // Response queue: stored age is the age the entry has in the cycle it is read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r  <= '0;
            wr_ptr_r  <= '0;
            q_count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data_r[i] <= 32'h0;
                q_age_r[i]  <= 3'd0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (q_age_r[i] < LAT_V) begin
                    q_age_r[i] <= q_age_r[i] + 3'd1;
                end
            end
            if (push_s) begin
                q_data_r[wr_ptr_r] <= push_data_s;
                q_age_r[wr_ptr_r]  <= 3'd1;
                wr_ptr_r           <= next_ptr(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   q_count_r <= q_count_r + CNT_W'(1);
                2'b01:   q_count_r <= q_count_r - CNT_W'(1);
                default: q_count_r <= q_count_r;
            endcase
        end
    end

    // Outstanding count: up on accept, down in the cycle its data_ok is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else begin
            case ({accept_s, data_ok_r})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered response stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_ok_r <= 1'b0;
            rdata_r   <= 32'h0;
        end else begin
            data_ok_r <= resp_valid_s;
            rdata_r   <= resp_data_s;
        end
    end

endmodule

// File: tb/tb_sram_like_responder.sv
// Bench for sram_like_responder: LAT=1 and LAT=3 instances share stimulus; a response-time
// model (response cycle = max(accept+LAT, previous response+1)) is checked every cycle.
module tb_sram_like_responder;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 2;
    localparam int NI     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy_inject = 1'b0;
    logic        aok0, aok1, dok0, dok1;
    logic [31:0] rd0, rd1;

    always #5 clk = ~clk;

    sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .busy_inject(busy_inject), .addr_ok(aok0), .data_ok(dok0), .rdata(rd0)
    );

    sram_like_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .wstrb(wstrb), .addr(addr),
        .wdata(wdata), .busy_inject(busy_inject), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
    );

    int          errors;
    int          checks;
    int          cyc_n;
    int          p_resp [NI][8];
    logic [31:0] p_data [NI][8];
    int          p_n [NI];
    int          last_resp [NI];
    logic [31:0] mm [NI][1 << ADDR_W];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc_n, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model past this cycle.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            logic        e_aok, e_dok, a_aok, a_dok;
            logic [31:0] e_rd, a_rd, word;
            int          idx, r;
            a_aok = (i == 0) ? aok0 : aok1;
            a_dok = (i == 0) ? dok0 : dok1;
            a_rd  = (i == 0) ? rd0 : rd1;
            e_aok = !reset && !busy_inject && (p_n[i] < DEPTH);
            e_dok = 1'b0;
            e_rd  = 32'h0;
            if (!reset && p_n[i] > 0 && p_resp[i][0] == cyc_n) begin
                e_dok = 1'b1;
                e_rd  = p_data[i][0];
            end
            chk($sformatf("model addr_ok lat%0d", lat_of(i)), {31'h0, a_aok}, {31'h0, e_aok});
            chk($sformatf("model data_ok lat%0d", lat_of(i)), {31'h0, a_dok}, {31'h0, e_dok});
            chk($sformatf("model rdata lat%0d", lat_of(i)), a_rd, e_rd);
            if (reset) begin
                p_n[i]       = 0;
                last_resp[i] = -1000;
            end else begin
                if (e_dok) begin
                    for (int k = 0; k < 7; k++) begin
                        p_resp[i][k] = p_resp[i][k+1];
                        p_data[i][k] = p_data[i][k+1];
                    end
                    p_n[i]--;
                end
                if (req && e_aok) begin
                    idx  = int'(addr[ADDR_W+1:2]);
                    word = mm[i][idx];
                    if (wr) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
                        end
                        mm[i][idx] = word;
                        word = 32'h0;
                    end
                    r = cyc_n + lat_of(i);
                    if (r <= last_resp[i]) r = last_resp[i] + 1;
                    p_resp[i][p_n[i]] = r;
                    p_data[i][p_n[i]] = word;
                    p_n[i]++;
                    last_resp[i] = r;
                end
            end
        end
        cyc_n++;
    endtask

    task automatic drive(input logic r, input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic b, input logic rs);
        @(posedge clk);
        #1;
        req = r; wr = w; wstrb = s; addr = a; wdata = d; busy_inject = b; reset = rs;
        @(negedge clk);
        model_step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic rd_req(input logic [31:0] a, input logic b);
        drive(1'b1, 1'b0, 4'h0, a, 32'h0, b, 1'b0);
    endtask

    task automatic wr_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        drive(1'b1, 1'b1, s, a, d, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0]  e_aok33;
        logic [7:0]  e_dok33;
        logic [31:0] e_rd33;
        errors = 0;
        checks = 0;
        cyc_n  = 0;
        for (int i = 0; i < NI; i++) begin
            p_n[i]       = 0;
            last_resp[i] = -1000;
        end

        repeat (3) begin
            drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
            chk("reset addr_ok", {31'h0, aok1}, 32'h0);
            chk("reset data_ok", {31'h0, dok1}, 32'h0);
        end
        idle();
        chk("post-reset addr_ok lat1", {31'h0, aok0}, 32'h1);
        chk("post-reset addr_ok lat3", {31'h0, aok1}, 32'h1);

        // Give every word used later a known value in both instances.
        for (int w = 0; w < 32; w++) begin
            wr_req(32'(w * 4), 32'hA500_0000 | 32'(w), 4'hF);
            repeat (3) idle();
        end

        wr_req(32'h40, 32'hDEAD_BEEF, 4'hF);
        chk("wr40 addr_ok", {31'h0, aok0}, 32'h1);
        chk("wr40 no data_ok yet", {31'h0, dok0}, 32'h0);
        rd_req(32'h40, 1'b0);
        chk("wr40 data_ok", {31'h0, dok0}, 32'h1);
        chk("wr40 rdata", rd0, 32'h0);
        idle();
        chk("rd40 data_ok", {31'h0, dok0}, 32'h1);
        chk("rd40 rdata", rd0, 32'hDEAD_BEEF);
        repeat (4) idle();

        wr_req(32'h44, 32'h1122_3344, 4'hF);
        wr_req(32'h44, 32'h0000_AB00, 4'b0010);
        rd_req(32'h44, 1'b0);
        idle();
        chk("rd44 data_ok", {31'h0, dok0}, 32'h1);
        chk("rd44 merged rdata", rd0, 32'h1122_AB44);
        repeat (4) idle();

        // Three reads into the LAT=3 / DEPTH=2 instance, third held until accepted.
        e_aok33 = 8'hF3;
        e_dok33 = 8'h98;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) rd_req(32'h14, 1'b0);
            else if (k == 1) rd_req(32'h18, 1'b0);
            else if (k <= 4) rd_req(32'h1C, 1'b0);
            else idle();
            case (k)
                3:       e_rd33 = 32'hA500_0005;
                4:       e_rd33 = 32'hA500_0006;
                7:       e_rd33 = 32'hA500_0007;
                default: e_rd33 = 32'h0;
            endcase
            chk($sformatf("fill addr_ok k%0d", k), {31'h0, aok1}, {31'h0, e_aok33[k]});
            chk($sformatf("fill data_ok k%0d", k), {31'h0, dok1}, {31'h0, e_dok33[k]});
            chk($sformatf("fill rdata k%0d", k), rd1, e_rd33);
        end
        repeat (4) idle();

        for (int k = 0; k < 5; k++) begin
            rd_req(32'h24, 1'b1);
            chk("busy addr_ok lat1", {31'h0, aok0}, 32'h0);
            chk("busy addr_ok lat3", {31'h0, aok1}, 32'h0);
            chk("busy data_ok lat3", {31'h0, dok1}, 32'h0);
        end
        rd_req(32'h24, 1'b0);
        chk("release addr_ok lat3", {31'h0, aok1}, 32'h1);
        idle();
        chk("release data_ok lat1", {31'h0, dok0}, 32'h1);
        chk("release rdata lat1", rd0, 32'hA500_0009);
        idle();
        chk("release early data_ok lat3", {31'h0, dok1}, 32'h0);
        idle();
        chk("release data_ok lat3", {31'h0, dok1}, 32'h1);
        chk("release rdata lat3", rd1, 32'hA500_0009);
        repeat (3) idle();

        rd_req(32'h08, 1'b0);
        rd_req(32'h0C, 1'b0);
        repeat (2) begin
            drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
            chk("flush data_ok in reset", {31'h0, dok1}, 32'h0);
        end
        idle();
        chk("flush addr_ok after reset", {31'h0, aok1}, 32'h1);
        repeat (5) begin
            idle();
            chk("flush no stale data_ok", {31'h0, dok1}, 32'h0);
        end

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] rnd;
            logic [4:0]  w5;
            rnd = $urandom();
            w5  = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                  {rnd[31:12], 5'b0, w5, rnd[1:0]}, $urandom(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        repeat (8) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
